regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file, successor to the single-write/dual-read RF.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rd_port.sv | 39 +++
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state encoding,
// the hard-wired zero register index and the slice-offset helper for flattened port buses.
package regfile_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam int REG_ZERO = 0;

    // Low bit of element idx in a bus built from equal-width fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One read port of the register file: zero register / clear-phase masking,
// priority write->read forwarding over all write ports, then the stored-value lookup.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_WR      = 1,
    parameter int BYPASS     = 1,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                        run,
    input  logic [ADDR_WIDTH-1:0]       raddr,
    input  logic [NR_WR-1:0]            wen,
    input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NR_WR*DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH*DATA_WIDTH-1:0] rf_flat,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] stored_val;

    assign stored_val = rf_flat[slice_lo(int'(raddr), DATA_WIDTH) +: DATA_WIDTH];

    always_comb begin
        rdata = '0;
        if (run && (raddr != ADDR_WIDTH'(REG_ZERO))) begin
            rdata = stored_val;
            // Ascending scan so the highest-index enabled writer is the one forwarded.
            for (int i = 0; i < NR_WR; i++) begin
                if ((BYPASS != 0) && wen[i] &&
                    (waddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == raddr)) begin
                    rdata = wdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register write decode, post-reset clear
// sweep (ready flag) and a flattened debug view of the stored contents.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_RD      = 2,
    parameter int NR_WR      = 1,
    parameter int BYPASS     = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NR_WR-1:0]                     wen,
    input  logic [NR_WR*ADDR_WIDTH-1:0]          waddr,
    input  logic [NR_WR*DATA_WIDTH-1:0]          wdata,
    input  logic [NR_RD*ADDR_WIDTH-1:0]          raddr,
    output logic [NR_RD*DATA_WIDTH-1:0]          rdata,
    output logic                                 ready,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] dbg_rf
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    rf_state_e             state_reg, state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;
    logic                  run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= RF_INIT;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            RF_INIT: begin
                clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
                if (&clr_cnt_reg) begin
                    state_next = RF_RUN;
                end
            end
            RF_RUN: begin
                state_next = RF_RUN;
            end
            default: begin
                state_next = RF_INIT;
            end
        endcase
    end

    assign run   = (state_reg == RF_RUN);
    assign ready = run;

    // Register 0 has no storage; its debug slice is tied low.
    assign dbg_rf[0 +: DATA_WIDTH] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] val_reg;
            logic                  hit;
            logic [DATA_WIDTH-1:0] hit_data;

            // Later ports overwrite earlier matches, giving the highest index priority.
            always_comb begin
                hit      = 1'b0;
                hit_data = '0;
                for (int i = 0; i < NR_WR; i++) begin
                    if (wen[i] &&
                        (waddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(gi))) begin
                        hit      = 1'b1;
                        hit_data = wdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!run) begin
                    if (clr_cnt_reg == ADDR_WIDTH'(gi)) begin
                        val_reg <= '0;
                    end
                end else if (hit) begin
                    val_reg <= hit_data;
                end
            end

            assign dbg_rf[slice_lo(gi, DATA_WIDTH) +: DATA_WIDTH] = val_reg;
        end

        for (gi = 0; gi < NR_RD; gi++) begin : g_rd
            regfile_rd_port #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .NR_WR      (NR_WR),
                .BYPASS     (BYPASS),
                .DEPTH      (DEPTH)
            ) u_rd (
                .run     (run),
                .raddr   (raddr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH]),
                .wen     (wen),
                .waddr   (waddr),
                .wdata   (wdata),
                .rf_flat (dbg_rf),
                .rdata   (rdata[slice_lo(gi, DATA_WIDTH) +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 3-read/2-write bypassing instance and a 2-read/1-write
// non-bypassing instance share one stimulus stream and are checked against hand tables and a model.
module tb_regfile_mp;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wen_a;
    logic [9:0]    waddr_a;
    logic [63:0]   wdata_a;
    logic [14:0]   raddr_a;
    logic [95:0]   rdata_a;
    logic          ready_a;
    logic [1023:0] dbg_a;

    logic [0:0]    wen_b;
    logic [4:0]    waddr_b;
    logic [31:0]   wdata_b;
    logic [9:0]    raddr_b;
    logic [63:0]   rdata_b;
    logic          ready_b;
    logic [1023:0] dbg_b;

    assign wen_b   = wen_a[0];
    assign waddr_b = waddr_a[4:0];
    assign wdata_b = wdata_a[31:0];
    assign raddr_b = raddr_a[9:0];

    always #5 clk = ~clk;

    regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RD(3), .NR_WR(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a),
        .raddr(raddr_a), .rdata(rdata_a), .ready(ready_a), .dbg_rf(dbg_a)
    );

    regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_RD(2), .NR_WR(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b),
        .raddr(raddr_b), .rdata(rdata_b), .ready(ready_b), .dbg_rf(dbg_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] ma [32];
    logic [31:0] mb [32];

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] ea0, ea1, ea2;
        logic [31:0] eb0, eb1;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_flat(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            for (int k = 0; k < 32; k++) begin
                if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
                    $display("FAIL %s @%0t: reg %0d got %h expected %h",
                             name, $time, k, act[k*32 +: 32], exp[k*32 +: 32]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [1023:0] flat(input logic [31:0] m [32]);
        logic [1023:0] f;
        for (int k = 0; k < 32; k++) f[k*32 +: 32] = m[k];
        return f;
    endfunction

    function automatic logic [31:0] exp_a(input int j);
        logic [4:0]  ra;
        logic [31:0] r;
        ra = raddr_a[j*5 +: 5];
        r  = ma[ra];
        for (int i = 0; i < 2; i++)
            if (wen_a[i] && waddr_a[i*5 +: 5] == ra) r = wdata_a[i*32 +: 32];
        if (ra == 5'd0) r = '0;
        return r;
    endfunction

    function automatic logic [31:0] exp_b(input int j);
        logic [4:0] ra;
        ra = raddr_a[j*5 +: 5];
        return (ra == 5'd0) ? 32'h0 : mb[ra];
    endfunction

    // Inputs already applied and settled; check against the model, then clock and update it.
    task automatic step();
        for (int j = 0; j < 3; j++) chk($sformatf("model_a_rd%0d", j), rdata_a[j*32 +: 32], exp_a(j));
        for (int j = 0; j < 2; j++) chk($sformatf("model_b_rd%0d", j), rdata_b[j*32 +: 32], exp_b(j));
        chk_flat("model_dbg_a", dbg_a, flat(ma));
        chk_flat("model_dbg_b", dbg_b, flat(mb));
        chk("ready_a", {31'd0, ready_a}, 32'd1);
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            if (wen_a[i] && waddr_a[i*5 +: 5] != 5'd0) ma[waddr_a[i*5 +: 5]] = wdata_a[i*32 +: 32];
        if (wen_a[0] && waddr_a[4:0] != 5'd0) mb[waddr_a[4:0]] = wdata_a[31:0];
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int cnt = 0;
        while (!ready_a && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!ready_a) chk({name, "_init_rd"}, rdata_a[31:0], 32'h0);
        end
        chk({name, "_len"}, cnt, 32'd32);
        chk({name, "_ready_b"}, {31'd0, ready_b}, 32'd1);
        @(negedge clk);
    endtask

    task automatic fill();
        for (int k = 1; k < 32; k++) begin
            wen_a   = 2'b01;
            waddr_a = {5'd0, 5'(k)};
            wdata_a = {32'h0, 32'(k)};
            @(negedge clk);
        end
        wen_a = 2'b00;
        #1;
        chk("fill_a_r5", dbg_a[5*32 +: 32], 32'd5);
        chk("fill_b_r31", dbg_b[31*32 +: 32], 32'd31);
    endtask

    task automatic chk_all_zero(input string name);
        #1;
        chk_flat({name, "_dbg_a"}, dbg_a, '0);
        chk_flat({name, "_dbg_b"}, dbg_b, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b01,  5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 5'd5,  5'd5, 5'd0,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{2'b00,  5'd0, 32'h0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5,
                     32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{2'b01,  5'd0, 32'h1234, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3]  = '{2'b01,  5'd7, 32'hA5A5A5A5, 5'd0, 32'd0, 5'd7, 5'd7, 5'd5,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0, 32'h0};
        vecs[4]  = '{2'b00,  5'd0, 32'h0, 5'd0, 32'd0, 5'd7, 5'd7, 5'd0,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[5]  = '{2'b11,  5'd3, 32'd1, 5'd3, 32'd2, 5'd3, 5'd3, 5'd7,
                     32'd2, 32'd2, 32'hA5A5A5A5, 32'h0, 32'h0};
        vecs[6]  = '{2'b00,  5'd0, 32'h0, 5'd0, 32'd0, 5'd3, 5'd3, 5'd0,
                     32'd2, 32'd2, 32'h0, 32'd1, 32'd1};
        vecs[7]  = '{2'b11,  5'd3, 32'd1, 5'd4, 32'd2, 5'd3, 5'd4, 5'd5,
                     32'd1, 32'd2, 32'hDEADBEEF, 32'd1, 32'h0};
        vecs[8]  = '{2'b00,  5'd0, 32'h0, 5'd0, 32'd0, 5'd3, 5'd4, 5'd7,
                     32'd1, 32'd2, 32'hA5A5A5A5, 32'd1, 32'h0};
        vecs[9]  = '{2'b11,  5'd31, 32'hFFFFFFFF, 5'd0, 32'd5, 5'd31, 5'd0, 5'd31,
                     32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0};
        vecs[10] = '{2'b00,  5'd0, 32'h0, 5'd0, 32'd0, 5'd31, 5'd0, 5'd3,
                     32'hFFFFFFFF, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0};

        // Power-up reset sweep, with writes attempted during the clear phase.
        rst = 1'b1; wen_a = '0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready_a", {31'd0, ready_a}, 32'd0);
        chk("rst_rdata_a", rdata_a[31:0], 32'd0);
        rst     = 1'b0;
        wen_a   = 2'b11;
        waddr_a = {5'd10, 5'd9};
        wdata_a = {32'd88, 32'd77};
        raddr_a = {5'd10, 5'd10, 5'd9};
        wait_ready("sweep1");
        wen_a = 2'b00;
        chk_all_zero("sweep1");

        // Reset from RUN restarts the sweep.
        fill();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        raddr_a = {5'd3, 5'd2, 5'd1};
        wait_ready("run_rst");
        chk_all_zero("run_rst");

        // Reset again while the sweep is at clr_cnt=10.
        fill();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("midinit_ready", {31'd0, ready_a}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready("init_rst");
        chk_all_zero("init_rst");

        for (int k = 0; k < 32; k++) begin
            ma[k] = '0;
            mb[k] = '0;
        end

        // Directed table: basic write/read, register 0, bypass and conflict cases.
        for (int v = 0; v < 11; v++) begin
            wen_a   = vecs[v].wen;
            waddr_a = {vecs[v].wa1, vecs[v].wa0};
            wdata_a = {vecs[v].wd1, vecs[v].wd0};
            raddr_a = {vecs[v].ra2, vecs[v].ra1, vecs[v].ra0};
            #1;
            chk($sformatf("vec%0d_a_rd0", v), rdata_a[31:0],  vecs[v].ea0);
            chk($sformatf("vec%0d_a_rd1", v), rdata_a[63:32], vecs[v].ea1);
            chk($sformatf("vec%0d_a_rd2", v), rdata_a[95:64], vecs[v].ea2);
            chk($sformatf("vec%0d_b_rd0", v), rdata_b[31:0],  vecs[v].eb0);
            chk($sformatf("vec%0d_b_rd1", v), rdata_b[63:32], vecs[v].eb1);
            step();
        end
        #1;
        chk("tbl_dbg_a_r3",  dbg_a[3*32 +: 32],  32'd1);
        chk("tbl_dbg_a_r4",  dbg_a[4*32 +: 32],  32'd2);
        chk("tbl_dbg_a_r7",  dbg_a[7*32 +: 32],  32'hA5A5A5A5);
        chk("tbl_dbg_a_r0",  dbg_a[31:0],        32'h0);
        chk("tbl_dbg_b_r5",  dbg_b[5*32 +: 32],  32'hDEADBEEF);
        chk("tbl_dbg_b_r0",  dbg_b[31:0],        32'h0);

        // Random traffic against the model, biased toward address collisions.
        for (int c = 0; c < 10000; c++) begin
            logic [4:0] a0, a1;
            a0 = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            wen_a   = 2'($urandom_range(0, 3));
            waddr_a = {a1, a0};
            wdata_a = {32'($urandom), 32'($urandom)};
            raddr_a = {($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31))};
            #1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
